// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: step-rate prescaler and pattern/step sequencer for the
// 16-LED pattern datapath. It produces {pat_sel, step} for the downstream
// pattern ROM, together with step_tick, frame_done and blank. Every output
// is registered.
//
// Build option: define LED_SEQ_REVERSE_EN to add the dir input. With dir=1
// the sequence steps downward. When the macro is undefined the design has no
// dir port and steps upward only.
module led_seq_ctrl #(
   parameter int unsigned FAST_DIV = 11,  // clocks per step when speed=0
   parameter int unsigned SLOW_DIV = 41,  // clocks per step when speed=1
   parameter int unsigned NUM_PAT  = 6,   // number of patterns (1..8)
   parameter int unsigned PAT0_LEN = 16,  // steps in pattern 0
   parameter int unsigned PAT_LEN  = 8    // steps in patterns 1..NUM_PAT-1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       speed,
   input  logic       en,
   input  logic       pause,
   input  logic       auto_cycle,
   input  logic       next_pat,
`ifdef LED_SEQ_REVERSE_EN
   input  logic       dir,
`endif
   output logic [2:0] pat_sel,
   output logic [3:0] step,
   output logic       step_tick,
   output logic       frame_done,
   output logic       blank
);

   localparam logic [1:0] ST_OFF   = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_PAUSE = 2'd2;

   // The prescaler counts 0..DIV-1, so it compares against DIV-1.
   localparam logic [15:0] FAST_TOP = 16'(FAST_DIV - 1);
   localparam logic [15:0] SLOW_TOP = 16'(SLOW_DIV - 1);

   // Index of the last step of pattern p.
   function automatic logic [3:0] last_step(input logic [2:0] p);
      return (p == 3'd0) ? 4'(PAT0_LEN - 1) : 4'(PAT_LEN - 1);
   endfunction

   // Pattern index after p, wrapping at NUM_PAT.
   function automatic logic [2:0] pat_inc(input logic [2:0] p);
      return (p == 3'(NUM_PAT - 1)) ? 3'd0 : p + 3'd1;
   endfunction

   logic [1:0]  state_q, state_d;
   logic [2:0]  pat_q, pat_d;
   logic [3:0]  step_q, step_d;
   logic [15:0] cnt_q, cnt_d;
   logic        speed_q;
   logic        tick_q, tick_d;
   logic        fd_q, fd_d;
   logic        blank_q, blank_d;

   logic        step_down;
   logic        speed_chg;
   logic [15:0] cnt_top;
   logic [2:0]  adv_pat;
   logic [3:0]  adv_step;
   logic        adv_wrap;

`ifdef LED_SEQ_REVERSE_EN
   assign step_down = dir;
`else
   assign step_down = 1'b0;
`endif

   // A speed change restarts the prescaler with the new divider.
   assign speed_chg = (speed != speed_q);
   assign cnt_top   = speed_q ? SLOW_TOP : FAST_TOP;

   // Where a prescaler tick would move the sequence from its current position.
   always_comb begin
      adv_pat  = pat_q;
      adv_step = step_q;
      adv_wrap = 1'b0;
      if (step_down) begin
         if (step_q != 4'd0) begin
            adv_step = step_q - 4'd1;
         end else begin
            adv_wrap = 1'b1;
            if (auto_cycle) begin
               adv_pat = pat_inc(pat_q);
            end
            // Downward wrap lands on the last step of the resulting pattern.
            adv_step = last_step(adv_pat);
         end
      end else begin
         if (step_q < last_step(pat_q)) begin
            adv_step = step_q + 4'd1;
         end else begin
            adv_wrap = 1'b1;
            adv_step = 4'd0;
            if (auto_cycle) begin
               adv_pat = pat_inc(pat_q);
            end
         end
      end
   end

   // Next-state logic: en=0 beats next_pat, next_pat beats pause and ticks,
   // and pause beats a tick (the counter is simply held).
   always_comb begin
      state_d = state_q;
      pat_d   = pat_q;
      step_d  = step_q;
      cnt_d   = cnt_q;
      tick_d  = 1'b0;
      fd_d    = 1'b0;
      case (state_q)
         ST_RUN, ST_PAUSE: begin
            if (!en) begin
               state_d = ST_OFF;
               pat_d   = 3'd0;
               step_d  = 4'd0;
               cnt_d   = 16'd0;
            end else if (next_pat) begin
               pat_d   = pat_inc(pat_q);
               step_d  = 4'd0;
               cnt_d   = 16'd0;
               tick_d  = 1'b1;
               state_d = pause ? ST_PAUSE : ST_RUN;
            end else if (pause) begin
               state_d = ST_PAUSE;
            end else if (state_q == ST_PAUSE) begin
               // Release: the counter stays frozen this cycle and resumes
               // counting in the first RUN cycle.
               state_d = ST_RUN;
            end else if (!speed_chg) begin
               if (cnt_q == cnt_top) begin
                  cnt_d  = 16'd0;
                  pat_d  = adv_pat;
                  step_d = adv_step;
                  fd_d   = adv_wrap;
                  tick_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + 16'd1;
               end
            end
         end
         default: begin
            // OFF (and any unused encoding): parked at pattern 0, step 0.
            state_d = en ? ST_RUN : ST_OFF;
            pat_d   = 3'd0;
            step_d  = 4'd0;
            cnt_d   = 16'd0;
         end
      endcase
      // A change of the registered speed always restarts the count.
      if (speed_chg) begin
         cnt_d = 16'd0;
      end
      blank_d = (state_d == ST_OFF);
   end

   // State, prescaler and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_OFF;
         pat_q   <= 3'd0;
         step_q  <= 4'd0;
         cnt_q   <= 16'd0;
         speed_q <= 1'b0;
         tick_q  <= 1'b0;
         fd_q    <= 1'b0;
         blank_q <= 1'b1;
      end else begin
         state_q <= state_d;
         pat_q   <= pat_d;
         step_q  <= step_d;
         cnt_q   <= cnt_d;
         speed_q <= speed;
         tick_q  <= tick_d;
         fd_q    <= fd_d;
         blank_q <= blank_d;
      end
   end

   assign pat_sel    = pat_q;
   assign step       = step_q;
   assign step_tick  = tick_q;
   assign frame_done = fd_q;
   assign blank      = blank_q;

endmodule
